// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs decoded RV32I instruction fields into 32-bit
// words and streams them, tagged with byte addresses, toward an imem write
// port. A single output register gives latency 1 with full throughput.
module instr_encode_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [2:0]        func3,
  input  logic              func7_b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
  localparam logic [31:0]       NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] remaining_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              out_valid_reg;
  logic [31:0]       out_instr_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic              err_reg;

  logic        accept;
  logic [31:0] enc_word;
  logic        enc_err;
  logic [11:0] imm_i;
  logic [6:0]  f7;
  logic        shift_op;
  logic        imm12_ok;
  logic        shamt_ok;
  logic        upper_ok;
  logic        jal_ok;

  assign in_ready  = (state_reg == LOAD) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_addr  = out_addr_reg;
  assign err       = err_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FINISH);

  // Immediate legality: a value fits a signed field when all bits above the
  // field's sign bit replicate it.
  assign f7       = func7_b5 ? 7'b0100000 : 7'b0000000;
  assign shift_op = (func3 == 3'd1) || (func3 == 3'd5);
  assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign shamt_ok = (imm[31:5] == '0);
  assign upper_ok = (imm[11:0] == '0);
  assign jal_ok   = !imm[0] && ((imm[31:20] == '0) || (imm[31:20] == '1));

  // Field packer: select layout by format, substitute NOP on range error.
  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    imm_i    = imm[11:0];
    case (fmt)
      3'd0: enc_word = {f7, rs2, rs1, func3, rd, 7'b0110011};
      3'd1: begin
        if (shift_op) begin
          imm_i   = {f7, imm[4:0]};
          enc_err = !shamt_ok;
        end else begin
          enc_err = !imm12_ok;
        end
        enc_word = {imm_i, rs1, func3, rd, 7'b0010011};
      end
      3'd2: begin
        enc_err  = !imm12_ok;
        enc_word = {imm[11:0], rs1, func3, rd, 7'b0000011};
      end
      3'd3: begin
        enc_err  = !imm12_ok;
        enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      end
      3'd4: begin
        enc_err  = !imm12_ok;
        enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], 7'b0100011};
      end
      3'd5: begin
        enc_err  = !upper_ok;
        enc_word = {imm[31:12], rd, 7'b0110111};
      end
      3'd6: begin
        enc_err  = !upper_ok;
        enc_word = {imm[31:12], rd, 7'b0010111};
      end
      default: begin
        enc_err  = !jal_ok;
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
    endcase
    if (enc_err) begin
      enc_word = NOP;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a zero-length load goes straight to the done pulse.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (count != '0) ? LOAD : FINISH;
        end
      end
      LOAD: begin
        if (accept && (remaining_reg == ADDR_W'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_reg || out_ready) begin
          state_next = FINISH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load setup, output register, address/remaining counters, sticky err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_reg <= '0;
      addr_reg      <= BASE;
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_addr_reg  <= BASE;
      err_reg       <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        remaining_reg <= count;
        addr_reg      <= BASE;
        err_reg       <= 1'b0;
      end
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= enc_word;
        out_addr_reg  <= addr_reg;
        addr_reg      <= addr_reg + ADDR_W'(4);
        remaining_reg <= remaining_reg - ADDR_W'(1);
        if (enc_err) begin
          err_reg <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule
